// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: field widths, ID/EX stage FSM encoding,
// the ID/EX payload record and a saturating counter helper.
package pipeline_pkg;

    localparam int ALU_OP_W = 4;
    localparam int REG_W    = 5;
    localparam int DATA_W   = 32;
    localparam int CNT_W    = 16;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_HOLD       = 2'd1,
        ST_FLUSH_PEND = 2'd2
    } stage_state_e;

    typedef struct packed {
        logic                valid;
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic                mem_to_reg;
        logic                alu_src;
        logic [REG_W-1:0]    read_reg1;
        logic [REG_W-1:0]    read_reg2;
        logic [REG_W-1:0]    write_reg;
        logic [ALU_OP_W-1:0] alu_op;
        logic [DATA_W-1:0]   read_data1;
        logic [DATA_W-1:0]   read_data2;
        logic [DATA_W-1:0]   imm;
        logic [DATA_W-1:0]   pc;
    } id_ex_t;

    // A bubble is an all-zero slot: no valid bit, no architectural side effects.
    localparam id_ex_t ID_EX_BUBBLE = '0;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (value == {CNT_W{1'b1}}) begin
            result = value;
        end else begin
            result = value + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return result;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: the load in EX writes a register that the
// instruction in decode wants to read, so that instruction must wait a cycle.
module load_use_detect
    import pipeline_pkg::*;
(
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_read_reg1,
    input  logic [REG_W-1:0] id_read_reg2,
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_write_reg,
    output logic             load_use_stall
);

    logic dest_live_s;
    logic src_match_s;

    // r0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign dest_live_s    = ex_valid & ex_mem_read & (ex_write_reg != {REG_W{1'b0}});
    assign src_match_s    = (ex_write_reg == id_read_reg1) | (ex_write_reg == id_read_reg2);
    assign load_use_stall = id_valid & dest_live_s & src_match_s;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush handling
// across memory stalls, PC/IF-ID freeze control and a stall-cycle counter.
module id_ex_stage
    import pipeline_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [REG_W-1:0]    id_read_reg1,
    input  logic [REG_W-1:0]    id_read_reg2,
    input  logic [REG_W-1:0]    id_write_reg,
    input  logic                id_reg_write,
    input  logic                id_mem_read,
    input  logic                id_mem_write,
    input  logic                id_mem_to_reg,
    input  logic                id_alu_src,
    input  logic [ALU_OP_W-1:0] id_alu_op,
    input  logic [DATA_W-1:0]   id_read_data1,
    input  logic [DATA_W-1:0]   id_read_data2,
    input  logic [DATA_W-1:0]   id_imm,
    input  logic [DATA_W-1:0]   id_pc,
    input  logic                flush,
    input  logic                mem_stall,
    output logic                idEx_valid,
    output logic                idEx_reg_write,
    output logic                idEx_mem_read,
    output logic                idEx_mem_write,
    output logic                idEx_mem_to_reg,
    output logic                idEx_alu_src,
    output logic [REG_W-1:0]    idEx_read_reg1,
    output logic [REG_W-1:0]    idEx_read_reg2,
    output logic [REG_W-1:0]    idEx_write_reg,
    output logic [ALU_OP_W-1:0] idEx_alu_op,
    output logic [DATA_W-1:0]   idEx_read_data1,
    output logic [DATA_W-1:0]   idEx_read_data2,
    output logic [DATA_W-1:0]   idEx_imm,
    output logic [DATA_W-1:0]   idEx_pc,
    output logic                pc_write,
    output logic                ifId_write,
    output logic                load_use_stall,
    output logic [CNT_W-1:0]    stall_count
);

    stage_state_e     state_r;
    id_ex_t           id_ex_r;
    id_ex_t           capture_s;
    logic             load_use_stall_s;
    logic             pc_write_s;
    logic [CNT_W-1:0] stall_count_r;

    load_use_detect u_load_use_detect (
        .id_valid       (id_valid),
        .id_read_reg1   (id_read_reg1),
        .id_read_reg2   (id_read_reg2),
        .ex_valid       (id_ex_r.valid),
        .ex_mem_read    (id_ex_r.mem_read),
        .ex_write_reg   (id_ex_r.write_reg),
        .load_use_stall (load_use_stall_s)
    );

    // Front-end advance enable. HOLD and FLUSH_PEND only persist while
    // mem_stall is high; on the release edge the stage follows RUN rules,
    // so mem_stall alone covers the held states. A flush never freezes PC
    // because the redirected fetch has to proceed.
    always_comb begin
        pc_write_s = 1'b1;
        if (mem_stall) begin
            pc_write_s = 1'b0;
        end else if (load_use_stall_s && !flush) begin
            pc_write_s = 1'b0;
        end else begin
            pc_write_s = 1'b1;
        end
    end

    // RUN-rule capture value: flush and load-use both insert a bubble,
    // otherwise decode is latched with side-effect bits gated by id_valid.
    always_comb begin
        capture_s = ID_EX_BUBBLE;
        if (flush || load_use_stall_s) begin
            capture_s = ID_EX_BUBBLE;
        end else begin
            capture_s.valid      = id_valid;
            capture_s.reg_write  = id_reg_write & id_valid & (id_write_reg != {REG_W{1'b0}});
            capture_s.mem_read   = id_mem_read & id_valid;
            capture_s.mem_write  = id_mem_write & id_valid;
            capture_s.mem_to_reg = id_mem_to_reg;
            capture_s.alu_src    = id_alu_src;
            capture_s.read_reg1  = id_read_reg1;
            capture_s.read_reg2  = id_read_reg2;
            capture_s.write_reg  = id_write_reg;
            capture_s.alu_op     = id_alu_op;
            capture_s.read_data1 = id_read_data1;
            capture_s.read_data2 = id_read_data2;
            capture_s.imm        = id_imm;
            capture_s.pc         = id_pc;
        end
    end

    // Stage FSM and ID/EX register: hold during mem_stall, remember a flush
    // seen while held, and turn it into a bubble on the release edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_RUN;
            id_ex_r <= ID_EX_BUBBLE;
        end else begin
            case (state_r)
                ST_RUN, ST_HOLD: begin
                    if (mem_stall) begin
                        state_r <= flush ? ST_FLUSH_PEND : ST_HOLD;
                    end else begin
                        state_r <= ST_RUN;
                        id_ex_r <= capture_s;
                    end
                end
                ST_FLUSH_PEND: begin
                    if (mem_stall) begin
                        state_r <= ST_FLUSH_PEND;
                    end else begin
                        state_r <= ST_RUN;
                        id_ex_r <= ID_EX_BUBBLE;
                    end
                end
                default: begin
                    state_r <= ST_RUN;
                    id_ex_r <= ID_EX_BUBBLE;
                end
            endcase
        end
    end

    // Count every edge on which the front end was frozen, sticking at max.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count_r <= {CNT_W{1'b0}};
        end else if (!pc_write_s) begin
            stall_count_r <= sat_inc(stall_count_r);
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign idEx_valid      = id_ex_r.valid;
    assign idEx_reg_write  = id_ex_r.reg_write;
    assign idEx_mem_read   = id_ex_r.mem_read;
    assign idEx_mem_write  = id_ex_r.mem_write;
    assign idEx_mem_to_reg = id_ex_r.mem_to_reg;
    assign idEx_alu_src    = id_ex_r.alu_src;
    assign idEx_read_reg1  = id_ex_r.read_reg1;
    assign idEx_read_reg2  = id_ex_r.read_reg2;
    assign idEx_write_reg  = id_ex_r.write_reg;
    assign idEx_alu_op     = id_ex_r.alu_op;
    assign idEx_read_data1 = id_ex_r.read_data1;
    assign idEx_read_data2 = id_ex_r.read_data2;
    assign idEx_imm        = id_ex_r.imm;
    assign idEx_pc         = id_ex_r.pc;
    assign pc_write        = pc_write_s;
    assign ifId_write      = pc_write_s;
    assign load_use_stall  = load_use_stall_s;
    assign stall_count     = stall_count_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table, reset and
// saturation sequences, and randomized traffic against a behavioural model.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_read_reg1, id_read_reg2, id_write_reg;
    logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src;
    logic [3:0]  id_alu_op;
    logic [31:0] id_read_data1, id_read_data2, id_imm, id_pc;
    logic        flush, mem_stall;
    logic        idEx_valid, idEx_reg_write, idEx_mem_read, idEx_mem_write;
    logic        idEx_mem_to_reg, idEx_alu_src;
    logic [4:0]  idEx_read_reg1, idEx_read_reg2, idEx_write_reg;
    logic [3:0]  idEx_alu_op;
    logic [31:0] idEx_read_data1, idEx_read_data2, idEx_imm, idEx_pc;
    logic        pc_write, ifId_write, load_use_stall;
    logic [15:0] stall_count;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_read_reg1(id_read_reg1), .id_read_reg2(id_read_reg2), .id_write_reg(id_write_reg),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src), .id_alu_op(id_alu_op),
        .id_read_data1(id_read_data1), .id_read_data2(id_read_data2), .id_imm(id_imm), .id_pc(id_pc),
        .flush(flush), .mem_stall(mem_stall),
        .idEx_valid(idEx_valid), .idEx_reg_write(idEx_reg_write), .idEx_mem_read(idEx_mem_read),
        .idEx_mem_write(idEx_mem_write), .idEx_mem_to_reg(idEx_mem_to_reg), .idEx_alu_src(idEx_alu_src),
        .idEx_read_reg1(idEx_read_reg1), .idEx_read_reg2(idEx_read_reg2), .idEx_write_reg(idEx_write_reg),
        .idEx_alu_op(idEx_alu_op), .idEx_read_data1(idEx_read_data1), .idEx_read_data2(idEx_read_data2),
        .idEx_imm(idEx_imm), .idEx_pc(idEx_pc), .pc_write(pc_write), .ifId_write(ifId_write),
        .load_use_stall(load_use_stall), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        v, rw, mr, mw, mtr, as;
        logic [4:0]  r1, r2, wr;
        logic [3:0]  op;
        logic [31:0] d1, d2, imm, pc;
    } stage_t;

    typedef struct {
        logic       v;
        logic [4:0] r1, r2, wr;
        logic       rw, mr, fl, st;
        logic       e_lus, e_pcw, e_v, e_rw, e_mr;
        logic [4:0] e_wr;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t        vecs [14];
    stage_t      m_stage;
    bit          m_kill;
    logic [15:0] m_cnt;

    function automatic stage_t dut_stage();
        return {idEx_valid, idEx_reg_write, idEx_mem_read, idEx_mem_write, idEx_mem_to_reg,
                idEx_alu_src, idEx_read_reg1, idEx_read_reg2, idEx_write_reg, idEx_alu_op,
                idEx_read_data1, idEx_read_data2, idEx_imm, idEx_pc};
    endfunction

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                             input logic [4:0] wr, input logic rw, input logic mr);
        id_valid      = v;
        id_read_reg1  = r1;
        id_read_reg2  = r2;
        id_write_reg  = wr;
        id_reg_write  = rw;
        id_mem_read   = mr;
        id_mem_write  = 1'b0;
        id_mem_to_reg = mr;
        id_alu_src    = 1'b1;
        id_alu_op     = 4'd3;
        id_read_data1 = 32'hA000_0000 | 32'(wr);
        id_read_data2 = 32'hB000_0000 | 32'(r2);
        id_imm        = 32'h0000_0010;
        id_pc         = 32'h0000_1000 + 32'(wr) * 32'd4;
    endtask

    // One randomized cycle checked against the abstract model.
    task automatic rand_cycle(input int n);
        bit hazard, advance;
        id_valid      = ($urandom_range(0, 9) != 0);
        id_read_reg1  = 5'($urandom_range(0, 3));
        id_read_reg2  = 5'($urandom_range(0, 3));
        id_write_reg  = 5'($urandom_range(0, 3));
        id_reg_write  = 1'($urandom);
        id_mem_read   = 1'($urandom);
        id_mem_write  = 1'($urandom);
        id_mem_to_reg = 1'($urandom);
        id_alu_src    = 1'($urandom);
        id_alu_op     = 4'($urandom);
        id_read_data1 = $urandom;
        id_read_data2 = $urandom;
        id_imm        = $urandom;
        id_pc         = $urandom;
        flush         = ($urandom_range(0, 6) == 0);
        mem_stall     = ($urandom_range(0, 3) == 0);
        // A valid decode reading the destination of a real load still in EX must wait.
        hazard  = id_valid && m_stage.v && m_stage.mr && (m_stage.wr != 5'd0) &&
                  ((m_stage.wr == id_read_reg1) || (m_stage.wr == id_read_reg2));
        advance = !mem_stall && !(hazard && !flush);
        #1;
        chk($sformatf("rnd%0d lus", n), 160'(load_use_stall), 160'(hazard));
        chk($sformatf("rnd%0d pcw", n), 160'(pc_write), 160'(advance));
        chk($sformatf("rnd%0d ifid", n), 160'(ifId_write), 160'(advance));
        if (!advance && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (mem_stall) begin
            if (flush) m_kill = 1'b1;
        end else if (m_kill || flush || hazard) begin
            m_stage = '0;
            m_kill  = 1'b0;
        end else begin
            m_stage.v   = id_valid;
            m_stage.rw  = id_reg_write && id_valid && (id_write_reg != 5'd0);
            m_stage.mr  = id_mem_read && id_valid;
            m_stage.mw  = id_mem_write && id_valid;
            m_stage.mtr = id_mem_to_reg;
            m_stage.as  = id_alu_src;
            m_stage.r1  = id_read_reg1;
            m_stage.r2  = id_read_reg2;
            m_stage.wr  = id_write_reg;
            m_stage.op  = id_alu_op;
            m_stage.d1  = id_read_data1;
            m_stage.d2  = id_read_data2;
            m_stage.imm = id_imm;
            m_stage.pc  = id_pc;
        end
        tick();
        chk($sformatf("rnd%0d stage", n), 160'(dut_stage()), 160'(m_stage));
        chk($sformatf("rnd%0d cnt", n), 160'(stall_count), 160'(m_cnt));
    endtask

    initial begin
        //          v    r1    r2    wr     rw   mr   fl   st   lus  pcw  v    rw   mr   wr     cnt
        vecs[0]  = '{1'b1, 5'd1, 5'd2, 5'd5,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd5,  16'd0};
        vecs[1]  = '{1'b1, 5'd5, 5'd3, 5'd6,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  16'd1};
        vecs[2]  = '{1'b1, 5'd5, 5'd3, 5'd6,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd6,  16'd1};
        vecs[3]  = '{1'b1, 5'd1, 5'd2, 5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0,  16'd1};
        vecs[4]  = '{1'b1, 5'd0, 5'd0, 5'd7,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd7,  16'd1};
        vecs[5]  = '{1'b1, 5'd1, 5'd2, 5'd9,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd9,  16'd1};
        vecs[6]  = '{1'b1, 5'd3, 5'd9, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  16'd1};
        vecs[7]  = '{1'b1, 5'd1, 5'd2, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd11, 16'd1};
        vecs[8]  = '{1'b1, 5'd3, 5'd4, 5'd12, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd11, 16'd2};
        vecs[9]  = '{1'b1, 5'd3, 5'd4, 5'd12, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd11, 16'd3};
        vecs[10] = '{1'b1, 5'd3, 5'd4, 5'd12, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd11, 16'd4};
        vecs[11] = '{1'b1, 5'd3, 5'd4, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  16'd4};
        vecs[12] = '{1'b1, 5'd3, 5'd4, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd14, 16'd4};
        vecs[13] = '{1'b0, 5'd3, 5'd4, 5'd15, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd15, 16'd4};

        rst = 1'b1;
        flush = 1'b0;
        mem_stall = 1'b0;
        set_instr(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        #2;
        chk("reset stage", 160'(dut_stage()), 160'(0));
        chk("reset cnt", 160'(stall_count), 160'(0));
        chk("reset pcw", 160'(pc_write), 160'(1));
        chk("reset ifid", 160'(ifId_write), 160'(1));
        tick();
        rst = 1'b0;

        // Directed vectors: load-use, r0 load, flush+hazard, stall with flush pulse.
        for (int i = 0; i < 14; i++) begin
            set_instr(vecs[i].v, vecs[i].r1, vecs[i].r2, vecs[i].wr, vecs[i].rw, vecs[i].mr);
            flush     = vecs[i].fl;
            mem_stall = vecs[i].st;
            #1;
            chk($sformatf("row%0d lus", i), 160'(load_use_stall), 160'(vecs[i].e_lus));
            chk($sformatf("row%0d pcw", i), 160'(pc_write), 160'(vecs[i].e_pcw));
            chk($sformatf("row%0d ifid", i), 160'(ifId_write), 160'(vecs[i].e_pcw));
            tick();
            chk($sformatf("row%0d valid", i), 160'(idEx_valid), 160'(vecs[i].e_v));
            chk($sformatf("row%0d regw", i), 160'(idEx_reg_write), 160'(vecs[i].e_rw));
            chk($sformatf("row%0d memrd", i), 160'(idEx_mem_read), 160'(vecs[i].e_mr));
            chk($sformatf("row%0d wr", i), 160'(idEx_write_reg), 160'(vecs[i].e_wr));
            chk($sformatf("row%0d cnt", i), 160'(stall_count), 160'(vecs[i].e_cnt));
        end

        // Reset asserted between edges while holding.
        flush = 1'b0;
        mem_stall = 1'b0;
        set_instr(1'b1, 5'd1, 5'd2, 5'd20, 1'b1, 1'b0);
        tick();
        chk("seqA capture", 160'(idEx_write_reg), 160'(20));
        mem_stall = 1'b1;
        tick();
        chk("seqA held", 160'(idEx_write_reg), 160'(20));
        chk("seqA cnt", 160'(stall_count), 160'(5));
        rst = 1'b1;
        #1;
        chk("seqA rst stage", 160'(dut_stage()), 160'(0));
        chk("seqA rst cnt", 160'(stall_count), 160'(0));
        chk("seqA rst pcw stall", 160'(pc_write), 160'(0));
        mem_stall = 1'b0;
        #1;
        chk("seqA rst pcw", 160'(pc_write), 160'(1));
        rst = 1'b0;

        // Reset while a flush is pending must discard it.
        set_instr(1'b1, 5'd1, 5'd2, 5'd21, 1'b1, 1'b0);
        tick();
        chk("seqB capture", 160'(idEx_write_reg), 160'(21));
        mem_stall = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        rst = 1'b1;
        #1;
        chk("seqB rst stage", 160'(dut_stage()), 160'(0));
        rst = 1'b0;
        mem_stall = 1'b0;
        set_instr(1'b1, 5'd1, 5'd2, 5'd22, 1'b1, 1'b0);
        tick();
        chk("seqB no bubble valid", 160'(idEx_valid), 160'(1));
        chk("seqB no bubble wr", 160'(idEx_write_reg), 160'(22));
        chk("seqB cnt", 160'(stall_count), 160'(0));

        // Randomized traffic from a clean reset.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        m_stage = '0;
        m_kill  = 1'b0;
        m_cnt   = 16'd0;
        for (int n = 0; n < 2000; n++) begin
            rand_cycle(n);
        end

        // Counter saturation.
        rst = 1'b1;
        flush = 1'b0;
        mem_stall = 1'b1;
        #1;
        rst = 1'b0;
        repeat (65535) @(posedge clk);
        #1;
        chk("sat reach", 160'(stall_count), 160'(16'hFFFF));
        repeat (5) @(posedge clk);
        #1;
        chk("sat nowrap", 160'(stall_count), 160'(16'hFFFF));
        mem_stall = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
